imem_port_arbiter: RTL and testbench

Shares the single 128-bit instruction-memory read port between the prefetch queue and a data-side load requester. It issues at most one aligned read per cycle and tracks in-flight reads through a fixed-latency return pipeline. Each returned line is routed to its owner, and fetch returns made stale by a redirect are squashed. It sits between the prefetch queue/LSU and the IMEM macro.

---
 rtl/imem_port_arbiter_pkg.sv | 43 ++++
 rtl/imem_inflight_tracker.sv | 42 ++++
 rtl/imem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_imem_port_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter_pkg
// Brief    : Shared types and helpers for the instruction-memory port arbiter:
//            read owner encoding, in-flight tracker entry, line alignment.
// Revision : 1.0 - initial release
// ============================================================================
package imem_port_arbiter_pkg;

  // A line is 128 bits, so the low 4 address bits select a byte within it.
  localparam int          LINE_OFFSET_BITS = 4;
  localparam logic [31:0] LINE_MASK        = ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_LOAD  = 1'b1
  } ImemOwner_;

  typedef struct packed {
    logic      valid;
    ImemOwner_ owner;
  } ImemInflight_;

  // Aligned IMEM address for a requester address.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & LINE_MASK;
  endfunction

  // Drop the valid bit of an entry whose owner is being squashed.
  function automatic ImemInflight_ squash_entry(input ImemInflight_ entry,
                                                input logic squash_fetch,
                                                input logic squash_load);
    ImemInflight_ result;
    result = entry;
    if ((entry.owner == OWNER_FETCH && squash_fetch) ||
        (entry.owner == OWNER_LOAD  && squash_load)) begin
      result.valid = 1'b0;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_inflight_tracker.sv
`default_nettype none
// ============================================================================
// Module   : imem_inflight_tracker
// Brief    : MEM_LATENCY-deep shift register of {valid, owner} that follows
//            each IMEM read to its return cycle. Entries of a squashed owner
//            lose their valid bit, including the one retiring this cycle.
// Revision : 1.0 - initial release
// ============================================================================
module imem_inflight_tracker
  import imem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  ImemInflight_ issue,
  input  logic         squash_fetch,
  input  logic         squash_load,
  output ImemInflight_ retire
);

  ImemInflight_ stage [MEM_LATENCY];

  // Stage 0 captures this cycle's grant; later stages shift, dropping squashed entries.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= squash_entry(issue, squash_fetch, squash_load);
      for (int i = 1; i < MEM_LATENCY; i++) begin
        stage[i] <= squash_entry(stage[i-1], squash_fetch, squash_load);
      end
    end
  end

  // The final stage is the read whose data is on memData this cycle.
  assign retire = squash_entry(stage[MEM_LATENCY-1], squash_fetch, squash_load);

endmodule
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter
// Brief    : Shares the 128-bit IMEM read port between the prefetch queue and
//            a data-side load requester. One aligned read per cycle, fixed
//            latency return routed to its owner, stale fetches squashed on
//            redirect.
// Config   : IMEM_ARB_STARVE_EN - when defined, a load refused STARVE_LIMIT
//            consecutive cycles wins the next grant over fetch.
// Revision : 1.0 - initial release
// ============================================================================
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         redirect,
  input  logic [31:0]  fetchRequestAddress,
  input  logic         fetchRequestValid,
  output logic [127:0] fetchData,
  output logic         fetchDataValid,
  input  logic [31:0]  loadRequestAddress,
  input  logic         loadRequestValid,
  output logic         loadRequestReady,
  output logic [127:0] loadData,
  output logic         loadDataValid,
  output logic [31:0]  memAddress,
  output logic         memRead,
  input  logic [127:0] memData
);

  logic         starve_force;
  logic         grant_fetch;
  logic         grant_load;
  ImemInflight_ issue;
  ImemInflight_ retire;
  logic         ret_fetch;
  logic         ret_load;
  logic [127:0] fetch_hold;
  logic [127:0] load_hold;

`ifdef IMEM_ARB_STARVE_EN
  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_count;

  // Count consecutive cycles an offered load is refused; acceptance restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_count <= '0;
    end else if (grant_load) begin
      starve_count <= '0;
    end else if (loadRequestValid && starve_count != STARVE_MAX) begin
      starve_count <= starve_count + 1'b1;
    end
  end

  assign starve_force = (starve_count == STARVE_MAX);
`else
  assign starve_force = 1'b0;
`endif

  // Pick at most one owner: a live fetch first unless the load is starved.
  always_comb begin
    grant_fetch = 1'b0;
    grant_load  = 1'b0;
    if (!reset) begin
      if (loadRequestValid &&
          (starve_force || !(fetchRequestValid && !redirect))) begin
        grant_load = 1'b1;
      end else if (fetchRequestValid && !redirect) begin
        grant_fetch = 1'b1;
      end
    end
  end

  // Drive the IMEM strobe/address and the tracker entry from the grant.
  always_comb begin
    memRead     = grant_fetch | grant_load;
    memAddress  = '0;
    issue.valid = grant_fetch | grant_load;
    issue.owner = grant_load ? OWNER_LOAD : OWNER_FETCH;
    if (grant_fetch) begin
      memAddress = line_align(fetchRequestAddress);
    end else if (grant_load) begin
      memAddress = line_align(loadRequestAddress);
    end
  end

  assign loadRequestReady = grant_load;

  imem_inflight_tracker #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_tracker (
    .clock        (clock),
    .reset        (reset),
    .issue        (issue),
    .squash_fetch (redirect),
    .squash_load  (1'b0),
    .retire       (retire)
  );

  assign ret_fetch = !reset && retire.valid && (retire.owner == OWNER_FETCH);
  assign ret_load  = !reset && retire.valid && (retire.owner == OWNER_LOAD);

  // Route the returning line to its owner; the other output keeps its last line.
  always_comb begin
    fetchDataValid = ret_fetch;
    loadDataValid  = ret_load;
    fetchData      = reset ? '0 : (ret_fetch ? memData : fetch_hold);
    loadData       = reset ? '0 : (ret_load  ? memData : load_hold);
  end

  // Remember the most recent line delivered to each owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_hold <= '0;
      load_hold  <= '0;
    end else begin
      if (ret_fetch) fetch_hold <= memData;
      if (ret_load)  load_hold  <= memData;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_port_arbiter
// Brief    : Directed plus randomized bench for imem_port_arbiter against a
//            transaction-level model (queue of pending returns with due cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

  localparam int LAT = 3;
  localparam int SL  = 4;
`ifdef IMEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         redirect;
  logic [31:0]  fetchRequestAddress;
  logic         fetchRequestValid;
  logic [127:0] fetchData;
  logic         fetchDataValid;
  logic [31:0]  loadRequestAddress;
  logic         loadRequestValid;
  logic         loadRequestReady;
  logic [127:0] loadData;
  logic         loadDataValid;
  logic [31:0]  memAddress;
  logic         memRead;
  logic [127:0] memData;

  imem_port_arbiter #(
    .MEM_LATENCY  (LAT),
    .STARVE_LIMIT (SL)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .redirect            (redirect),
    .fetchRequestAddress (fetchRequestAddress),
    .fetchRequestValid   (fetchRequestValid),
    .fetchData           (fetchData),
    .fetchDataValid      (fetchDataValid),
    .loadRequestAddress  (loadRequestAddress),
    .loadRequestValid    (loadRequestValid),
    .loadRequestReady    (loadRequestReady),
    .loadData            (loadData),
    .loadDataValid       (loadDataValid),
    .memAddress          (memAddress),
    .memRead             (memRead),
    .memData             (memData)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: each issued read returns at a known cycle to a known owner.
  int           due_q[$];
  bit           own_q[$];   // 0 = fetch, 1 = load
  int           starve = 0;
  logic [127:0] hold_f = '0;
  logic [127:0] hold_l = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit r, input bit rd,
                      input bit f, input logic [31:0] fa,
                      input bit l, input logic [31:0] la,
                      output bit accepted);
    bit           force_l, gl, gf, efv, elv;
    logic [31:0]  ea;
    logic [127:0] efd, eld;
    int           nd[$];
    bit           no[$];
    reset = r; redirect = rd;
    fetchRequestValid = f; fetchRequestAddress = fa;
    loadRequestValid  = l; loadRequestAddress  = la;
    memData = {$urandom, $urandom, $urandom, $urandom};
    #2;
    accepted = 1'b0;
    if (r) begin
      chk("rst_memRead", memRead, 0);
      chk("rst_memAddress", memAddress, 0);
      chk("rst_ready", loadRequestReady, 0);
      chk("rst_fdv", fetchDataValid, 0);
      chk("rst_ldv", loadDataValid, 0);
      chk("rst_fetchData", fetchData, 0);
      chk("rst_loadData", loadData, 0);
      due_q.delete(); own_q.delete();
      starve = 0; hold_f = '0; hold_l = '0;
    end else begin
      force_l = STARVE_EN && (starve == SL);
      gl = l && (force_l || !(f && !rd));
      gf = f && !rd && !gl;
      ea = gf ? (fa & 32'hFFFF_FFF0) : (gl ? (la & 32'hFFFF_FFF0) : 32'h0);
      // A redirect kills every fetch read still pending.
      if (rd) begin
        foreach (due_q[k]) if (own_q[k]) begin nd.push_back(due_q[k]); no.push_back(1'b1); end
        due_q = nd; own_q = no;
        nd.delete(); no.delete();
      end
      efv = 1'b0; elv = 1'b0;
      foreach (due_q[k]) if (due_q[k] == cyc) begin
        if (own_q[k]) elv = 1'b1; else efv = 1'b1;
      end
      efd = efv ? memData : hold_f;
      eld = elv ? memData : hold_l;
      chk("memRead", memRead, gf | gl);
      chk("memAddress", memAddress, ea);
      chk("loadRequestReady", loadRequestReady, gl);
      chk("fetchDataValid", fetchDataValid, efv);
      chk("loadDataValid", loadDataValid, elv);
      chk("fetchData", fetchData, efd);
      chk("loadData", loadData, eld);
      hold_f = efd; hold_l = eld;
      foreach (due_q[k]) if (due_q[k] != cyc) begin nd.push_back(due_q[k]); no.push_back(own_q[k]); end
      due_q = nd; own_q = no;
      if (gf | gl) begin due_q.push_back(cyc + LAT); own_q.push_back(gl); end
      if (gl) starve = 0;
      else if (l && starve < SL) starve++;
      accepted = gl;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit acc;
    bit pend_l;
    logic [31:0] pend_a;
    reset = 1'b1; redirect = 1'b0;
    fetchRequestValid = 1'b0; fetchRequestAddress = '0;
    loadRequestValid  = 1'b0; loadRequestAddress  = '0;
    memData = '0;
    @(posedge clock); #1;

    // Reset state
    step(1, 0, 0, 0, 0, 0, acc);
    step(1, 0, 1, 32'h1234, 1, 32'h200, acc);

    // Single fetch, aligned address, return after LAT cycles
    step(0, 0, 1, 32'h0000_1234, 0, 0, acc);
    for (int i = 0; i < LAT + 1; i++) step(0, 0, 0, 0, 0, 0, acc);

    // Fetch beats load, then load granted once fetch drops
    step(0, 0, 1, 32'h0000_4440, 1, 32'h200, acc);
    step(0, 0, 0, 0, 1, 32'h200, acc);
    for (int i = 0; i < LAT + 1; i++) step(0, 0, 0, 0, 0, 0, acc);

    // Two fetches squashed by a redirect; a load issued with the redirect returns
    step(0, 0, 1, 32'h100, 0, 0, acc);
    step(0, 0, 1, 32'h110, 0, 0, acc);
    step(0, 1, 0, 0, 1, 32'h300, acc);
    for (int i = 0; i < LAT + 1; i++) step(0, 0, 0, 0, 0, 0, acc);

    // Redirect with both requesters: load granted, stale fetch dropped
    step(0, 1, 1, 32'h500, 1, 32'h600, acc);
    for (int i = 0; i < LAT + 1; i++) step(0, 0, 0, 0, 0, 0, acc);

    // Both valid continuously: starvation relief only in the starve build
    for (int i = 0; i < 2 * SL + 4; i++) step(0, 0, 1, 32'h700 + 32'(i * 16), 1, 32'h800, acc);
    for (int i = 0; i < LAT + 1; i++) step(0, 0, 0, 0, 0, 0, acc);

    // Reset with reads in flight discards them
    step(0, 0, 1, 32'h900, 0, 0, acc);
    step(0, 0, 0, 0, 1, 32'hA00, acc);
    step(1, 0, 0, 0, 0, 0, acc);
    for (int i = 0; i < LAT + 2; i++) step(0, 0, 0, 0, 0, 0, acc);

    // Randomized traffic; load address held stable until accepted
    pend_l = 1'b0; pend_a = '0;
    for (int i = 0; i < 500; i++) begin
      bit r, rd, f;
      r  = ($urandom_range(0, 63) == 0);
      rd = ($urandom_range(0, 7) == 0);
      f  = ($urandom_range(0, 2) != 0);
      if (!pend_l && $urandom_range(0, 1) == 1) begin
        pend_l = 1'b1;
        pend_a = $urandom;
      end
      step(r, rd, f, $urandom, pend_l, pend_l ? pend_a : 32'h0, acc);
      if (acc) pend_l = 1'b0;
    end
    for (int i = 0; i < LAT + 1; i++) step(0, 0, 0, 0, 0, 0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
